fifo_rd_ctrl: RTL
=================

FIFO_RD_CTRL -- requirements
Module: fifo_rd_ctrl

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 8, giving the FIFO word and TX data width.
REQ-002 The block SHALL have parameter BUSY_TO, default 16, giving the number of cycles to wait for TX_BUSY before a retry.
REQ-003 The block SHALL have one clock and a synchronous, active-high reset, with these ports:
- CLK  in  1  sole clock; all logic on the rising edge.
- RST  in  1  synchronous, active-high reset.
- RD_EN  in  1  permission to start a new pop; a transfer already in flight always completes.
- EMPTY  in  1  FIFO read-side empty flag.
- RD_DATA  in  DATA_WIDTH  FIFO read data; valid and stable while EMPTY=0.
- R_INC  out  1  FIFO pop strobe; one-cycle pulse.
- TX_BUSY  in  1  downstream transmitter busy.
- TX_VALID  out  1  data-valid pulse to the transmitter.
- TX_DATA  out  DATA_WIDTH  registered byte presented to the transmitter.
- RETRY  out  1  one-cycle pulse on each timeout re-send.

Function
REQ-004 The block SHALL implement a Moore FSM with states IDLE, POP, SEND, WAIT_BUSY and WAIT_DONE; all outputs SHALL be registered or decoded from state only.
REQ-005 In IDLE, if RD_EN=1 and EMPTY=0, the FSM SHALL go to POP; otherwise it SHALL stay in IDLE.
REQ-006 In POP, R_INC SHALL be 1 for exactly one cycle, RD_DATA SHALL be captured into TX_DATA at the end of that cycle, and the FSM SHALL go to SEND unconditionally.
REQ-007 In SEND, TX_VALID SHALL be 1 for exactly one cycle, the timeout counter SHALL clear, and the FSM SHALL go to WAIT_BUSY.
REQ-008 In WAIT_BUSY:
- if TX_BUSY=1, the FSM SHALL go to WAIT_DONE;
- otherwise the counter SHALL increment;
- when the counter reaches BUSY_TO-1 with TX_BUSY still 0, the FSM SHALL go to SEND, re-sending the same TX_DATA, and pulse RETRY for one cycle.
REQ-009 In WAIT_DONE, the FSM SHALL go to IDLE when TX_BUSY=0 and otherwise stay.
REQ-010 Latency SHALL be as follows: EMPTY=0 with RD_EN=1 sampled in IDLE at edge N gives R_INC=1 in cycle N+1 and TX_VALID=1 in cycle N+2, with TX_DATA equal to the RD_DATA present in cycle N+1.
REQ-011 The block SHALL pop exactly one word per transfer and SHALL never assert R_INC outside POP, so a late EMPTY rise cannot cause a double pop.
REQ-012 TX_DATA SHALL stay constant from the end of POP until the next POP.
REQ-013 RD_EN falling in POP, SEND, WAIT_BUSY or WAIT_DONE SHALL NOT abort the transfer; RD_EN is checked only in IDLE.
REQ-014 EMPTY rising after POP SHALL NOT affect the transfer in flight.
REQ-015 The FSM SHALL return to IDLE for at least one cycle between transfers (minimum spacing of 5 cycles from one R_INC to the next).
REQ-016 The timeout counter SHALL be $clog2(BUSY_TO) bits wide and SHALL saturate at BUSY_TO-1.
REQ-017 Illegal state encodings SHALL recover to IDLE on the next edge.

Reset
REQ-018 With RST=1 at a rising edge, the FSM SHALL go to IDLE and R_INC, TX_VALID and RETRY SHALL be 0.
REQ-019 Reset SHALL clear TX_DATA, the timeout counter and BYTE_CNT (when present) to 0.
REQ-020 Reset asserted mid-transfer SHALL abandon the transfer without issuing any further R_INC or TX_VALID; a word already popped is lost.
REQ-021 Reset SHALL take priority over all other inputs.

Configuration
REQ-022 Macro FIFO_RD_CNT_EN SHALL control a transfer counter:
- defined: the block SHALL add output BYTE_CNT, 16 bits, incremented on each WAIT_DONE->IDLE transition and wrapping from 0xFFFF to 0x0000; retries SHALL NOT count.
- undefined: there SHALL be no BYTE_CNT port and no counter logic, and all other behaviour SHALL be identical.

Verification
REQ-023 Single word: EMPTY=0, RD_DATA=0xD0, RD_EN=1, TX model raises BUSY 1 cycle after TX_VALID and holds it 10 cycles -> one R_INC pulse, one TX_VALID pulse with TX_DATA=0xD0, FSM back in IDLE.
REQ-024 Burst: 10 words 0xD0..0xD9 in FIFO model -> 10 R_INC pulses, TX_DATA sequence 0xD0..0xD9 in order, R_INC spacing >= 5 cycles, BYTE_CNT=10 when FIFO_RD_CNT_EN is defined.
REQ-025 Timeout: TX_BUSY held 0, BUSY_TO=16 -> TX_VALID repeats every 17 cycles with the same TX_DATA, RETRY pulses alongside, no extra R_INC; releasing BUSY completes the transfer.
REQ-026 RD_EN gating: RD_EN dropped in the cycle after R_INC -> current byte still sent; no new R_INC while RD_EN=0 even with EMPTY=0.
REQ-027 Reset mid-transfer: RST=1 during WAIT_DONE -> next cycle all outputs 0 and FSM in IDLE; after release with EMPTY=0, normal pop resumes.
REQ-028 Wrap: with FIFO_RD_CNT_EN defined and BYTE_CNT forced to 0xFFFF, one transfer -> BYTE_CNT=0x0000.

Source files
------------

// File: rtl/fifo_rd_ctrl.sv
// FIFO read-side controller: pops one word, presents it to a transmitter and re-sends on busy timeout.
// Optional transfer counter (BYTE_CNT) is built when FIFO_RD_CNT_EN is defined.
module fifo_rd_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int BUSY_TO    = 16
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  RD_EN,
  input  logic                  EMPTY,
  input  logic [DATA_WIDTH-1:0] RD_DATA,
  output logic                  R_INC,
  input  logic                  TX_BUSY,
  output logic                  TX_VALID,
  output logic [DATA_WIDTH-1:0] TX_DATA,
  output logic                  RETRY,
`ifdef FIFO_RD_CNT_EN
  output logic [15:0]           BYTE_CNT,
`endif
  output logic [2:0]            DBG_STATE
);

  localparam int CNT_W = (BUSY_TO > 1) ? $clog2(BUSY_TO) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(BUSY_TO - 1);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_POP       = 3'd1,
    S_SEND      = 3'd2,
    S_WAIT_BUSY = 3'd3,
    S_WAIT_DONE = 3'd4
  } state_e;

  state_e                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0]   tx_data_q, tx_data_d;
  logic                    retry_q, retry_d;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      tx_data_q <= '0;
      retry_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      tx_data_q <= tx_data_d;
      retry_q   <= retry_d;
    end
  end

  // Handshake: TX_VALID is a one-cycle offer; the transmitter accepts it by
  // raising TX_BUSY, and lowering TX_BUSY later marks the word as finished.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    tx_data_d = tx_data_q;
    retry_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (RD_EN && !EMPTY) state_d = S_POP;
      end
      S_POP: begin
        tx_data_d = RD_DATA;
        state_d   = S_SEND;
      end
      S_SEND: begin
        cnt_d   = '0;
        state_d = S_WAIT_BUSY;
      end
      S_WAIT_BUSY: begin
        if (TX_BUSY) begin
          state_d = S_WAIT_DONE;
        end else if (cnt_q == CNT_MAX) begin
          state_d = S_SEND;
          retry_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_WAIT_DONE: begin
        if (!TX_BUSY) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

`ifdef FIFO_RD_CNT_EN
  logic [15:0] byte_cnt_q, byte_cnt_d;

  always_comb begin
    byte_cnt_d = byte_cnt_q;
    if (state_q == S_WAIT_DONE && !TX_BUSY) byte_cnt_d = byte_cnt_q + 16'd1;
  end

  always_ff @(posedge CLK) begin
    if (RST) byte_cnt_q <= '0;
    else     byte_cnt_q <= byte_cnt_d;
  end

  assign BYTE_CNT = byte_cnt_q;
`endif

  assign R_INC     = (state_q == S_POP);
  assign TX_VALID  = (state_q == S_SEND);
  assign RETRY     = retry_q;
  assign TX_DATA   = tx_data_q;
  assign DBG_STATE = state_q;

endmodule
